// File: rtl/vend_scheduler_pkg.sv
// Shared types and constants for the two-kiosk vending scheduler.
package vend_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam int NICKEL = 5;
   localparam int DIME   = 10;

   typedef logic port_t;

endpackage

// File: rtl/vend_scheduler_if.sv
// Coin-port and dispenser signals shared between the scheduler and its surroundings.
interface vend_scheduler_if #(parameter int CW = 6) ();

   logic [1:0]    coin_v;
   logic [1:0]    coin_d;
   logic [1:0]    cancel;
   logic          vend_done;
   logic          vend_go;
   logic          vend_port;
   logic [CW-1:0] vend_change;
   logic [1:0]    refund;
   logic [CW-1:0] refund_amt;
   logic [1:0]    reject;
   logic [1:0]    locked;
   logic          fault;

   modport slave (
      input  coin_v, coin_d, cancel, vend_done,
      output vend_go, vend_port, vend_change, refund, refund_amt, reject, locked, fault
   );

   modport master (
      output coin_v, coin_d, cancel, vend_done,
      input  vend_go, vend_port, vend_change, refund, refund_amt, reject, locked, fault
   );

endinterface

// File: rtl/vend_scheduler_credit.sv
// Per-port credit register with price lock, coin reject and refund request generation.
module vend_credit
   import vend_pkg::*;
#(
   parameter int PRICE = 15,
   parameter int CW    = 6
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          coin_v_i,
   input  logic          coin_d_i,
   input  logic          cancel_i,
   input  logic          clr_i,
   input  logic          rfd_gnt_i,
   output logic [CW-1:0] credit_o,
   output logic          locked_o,
   output logic          reject_o,
   output logic          rfd_req_o
);

   logic [CW-1:0] credit_q, credit_d, sum;
   logic          locked_q, locked_d;
   logic          pend_q, pend_d;
   logic          reject_q, reject_d;
   logic          cancel_ok, coin_ok;

   // A refund that lost arbitration stays pending; the port holds its credit and refuses coins.
   assign cancel_ok = cancel_i & ~locked_q & ~pend_q & (credit_q != '0);
   assign coin_ok   = coin_v_i & ~locked_q & ~pend_q & ~cancel_ok;
   assign rfd_req_o = cancel_ok | pend_q;
   assign sum       = credit_q + (coin_d_i ? CW'(DIME) : CW'(NICKEL));

   always_comb begin
      credit_d = credit_q;
      locked_d = locked_q;
      pend_d   = pend_q;
      reject_d = coin_v_i & ~coin_ok;
      if (clr_i) begin
         credit_d = '0;
         locked_d = 1'b0;
         pend_d   = 1'b0;
      end else if (rfd_req_o && rfd_gnt_i) begin
         credit_d = '0;
         pend_d   = 1'b0;
      end else if (cancel_ok) begin
         pend_d = 1'b1;
      end else if (coin_ok) begin
         credit_d = sum;
         locked_d = (sum >= CW'(PRICE));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credit_q <= '0;
         locked_q <= 1'b0;
         pend_q   <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         credit_q <= credit_d;
         locked_q <= locked_d;
         pend_q   <= pend_d;
         reject_q <= reject_d;
      end
   end

   assign credit_o = credit_q;
   assign locked_o = locked_q;
   assign reject_o = reject_q;

endmodule

// File: rtl/vend_scheduler.sv
// Shares one dispenser between two coin ports: round-robin grant FSM, watchdog and refund mux.
module vend_scheduler
   import vend_pkg::*;
#(
   parameter int PRICE   = 15,
   parameter int CW      = 6,
   parameter int TIMEOUT = 15
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   vend_scheduler_if.slave  bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e              state_q;
   port_t               port_q, last_q, sel;
   logic [TW-1:0]       cnt_q;
   logic                vend_go_q, fault_q, fault_d;
   logic [CW-1:0]       change_q, refund_amt_q, refund_amt_d;
   logic [1:0]          refund_q, refund_d;
   logic [1:0]          req, gnt, lock, rej, clr;
   logic [1:0][CW-1:0]  credit;

   for (genvar k = 0; k < 2; k++) begin : g_port
      vend_credit #(.PRICE(PRICE), .CW(CW)) u_credit (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .coin_v_i  (bus.coin_v[k]),
         .coin_d_i  (bus.coin_d[k]),
         .cancel_i  (bus.cancel[k]),
         .clr_i     (clr[k]),
         .rfd_gnt_i (gnt[k]),
         .credit_o  (credit[k]),
         .locked_o  (lock[k]),
         .reject_o  (rej[k]),
         .rfd_req_o (req[k])
      );
   end

   assign sel = (lock == 2'b11) ? ~last_q : lock[1];
   assign clr = {(state_q == S_DONE) && port_q, (state_q == S_DONE) && !port_q};

   // One refund slot per cycle: watchdog refund first, then port 0, then port 1.
   always_comb begin
      fault_d      = (state_q == S_WAIT) && !bus.vend_done && (cnt_q == TW'(TIMEOUT - 1));
      gnt          = '0;
      refund_d     = '0;
      refund_amt_d = '0;
      if (fault_d) begin
         refund_d[port_q] = 1'b1;
         refund_amt_d     = credit[port_q];
      end else if (req[0]) begin
         gnt[0]       = 1'b1;
         refund_d     = 2'b01;
         refund_amt_d = credit[0];
      end else if (req[1]) begin
         gnt[1]       = 1'b1;
         refund_d     = 2'b10;
         refund_amt_d = credit[1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         port_q       <= 1'b0;
         last_q       <= 1'b1;
         cnt_q        <= '0;
         vend_go_q    <= 1'b0;
         change_q     <= '0;
         fault_q      <= 1'b0;
         refund_q     <= '0;
         refund_amt_q <= '0;
      end else begin
         vend_go_q    <= 1'b0;
         change_q     <= '0;
         fault_q      <= fault_d;
         refund_q     <= refund_d;
         refund_amt_q <= refund_amt_d;
         case (state_q)
            S_IDLE: begin
               if (|lock) begin
                  port_q    <= sel;
                  vend_go_q <= 1'b1;
                  change_q  <= credit[sel] - CW'(PRICE);
                  state_q   <= S_GRANT;
               end
            end
            S_GRANT: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.vend_done || fault_d) state_q <= S_DONE;
               else                          cnt_q   <= cnt_q + TW'(1);
            end
            S_DONE: begin
               last_q  <= port_q;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.vend_go     = vend_go_q;
   assign bus.vend_port   = port_q;
   assign bus.vend_change = change_q;
   assign bus.refund      = refund_q;
   assign bus.refund_amt  = refund_amt_q;
   assign bus.reject      = rej;
   assign bus.locked      = lock;
   assign bus.fault       = fault_q;

endmodule

// File: tb/tb_vend_scheduler.sv
// Directed bench for vend_scheduler with PRICE=15, CW=6, TIMEOUT=15.
module tb_vend_scheduler;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   int   checks = 0;
   int   failures = 0;

   vend_scheduler_if #(.CW(6)) bus ();

   vend_scheduler #(.PRICE(15), .CW(6), .TIMEOUT(15)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] cv, cd, cn;
      logic       dn;
      logic       go;
      logic       pt;
      logic [5:0] chg;
      logic [1:0] rf;
      logic [5:0] amt;
      logic [1:0] rj, lk;
      logic       ft;
   } vec_t;

   vec_t tbl [12];

   function automatic logic [20:0] obs();
      return {bus.vend_go, bus.vend_port, bus.vend_change, bus.refund, bus.refund_amt,
              bus.reject, bus.locked, bus.fault};
   endfunction

   function automatic logic [16:0] refund_view();
      return {bus.refund, bus.refund_amt, bus.reject, bus.locked, bus.fault};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic [1:0] cv, input logic [1:0] cd, input logic [1:0] cn,
                      input logic dn);
      bus.coin_v    = cv;
      bus.coin_d    = cd;
      bus.cancel    = cn;
      bus.vend_done = dn;
      @(negedge clk);
      bus.coin_v    = 2'b00;
      bus.coin_d    = 2'b00;
      bus.cancel    = 2'b00;
      bus.vend_done = 1'b0;
   endtask

   task automatic expect_grant(input logic p, input logic [5:0] chg);
      bit seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         cyc(2'b00, 2'b00, 2'b00, 1'b0);
         if (bus.vend_go === 1'b1) seen = 1'b1;
      end
      chk("grant_seen", 32'(seen), 32'd1);
      if (seen) chk("grant_port_change", 32'({bus.vend_port, bus.vend_change}), 32'({p, chg}));
   endtask

   task automatic finish_vend(input logic [1:0] lk_exp);
      cyc(2'b00, 2'b00, 2'b00, 1'b0);
      cyc(2'b00, 2'b00, 2'b00, 1'b1);
      cyc(2'b00, 2'b00, 2'b00, 1'b0);
      chk("locked_after_done", 32'(bus.locked), 32'(lk_exp));
   endtask

   task automatic fill_port(input logic [1:0] ports);
      cyc(ports, ports, 2'b00, 1'b0);
      cyc(ports, 2'b00, 2'b00, 1'b0);
      chk("locked_after_fill", 32'(bus.locked), 32'(ports));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit early_fault;
      logic [20:0] exp;

      //         cv     cd     cn     dn    go    pt    chg    rf     amt    rj     lk     ft
      tbl[0]  = '{2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 2'b00, 2'b00, 1'b0};
      tbl[1]  = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 2'b00, 2'b01, 1'b0};
      tbl[2]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 6'd0, 2'b00, 6'd0, 2'b00, 2'b01, 1'b0};
      tbl[3]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 2'b00, 2'b01, 1'b0};
      tbl[4]  = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 2'b00, 2'b01, 1'b0};
      tbl[5]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 2'b00, 2'b00, 1'b0};
      tbl[6]  = '{2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 2'b00, 2'b00, 1'b0};
      tbl[7]  = '{2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 2'b00, 2'b10, 1'b0};
      tbl[8]  = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 6'd5, 2'b00, 6'd0, 2'b10, 2'b10, 1'b0};
      tbl[9]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 6'd0, 2'b00, 6'd0, 2'b00, 2'b10, 1'b0};
      tbl[10] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 6'd0, 2'b00, 6'd0, 2'b00, 2'b10, 1'b0};
      tbl[11] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 6'd0, 2'b00, 6'd0, 2'b00, 2'b00, 1'b0};

      bus.coin_v    = 2'b00;
      bus.coin_d    = 2'b00;
      bus.cancel    = 2'b00;
      bus.vend_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'(obs()), 32'd0);
      rst_ni = 1'b1;
      cyc(2'b00, 2'b00, 2'b00, 1'b0);
      chk("post_reset_idle", 32'(obs()), 32'd0);

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].cv, tbl[i].cd, tbl[i].cn, tbl[i].dn);
         exp = {tbl[i].go, tbl[i].pt, tbl[i].chg, tbl[i].rf, tbl[i].amt,
                tbl[i].rj, tbl[i].lk, tbl[i].ft};
         chk($sformatf("vec%0d", i), 32'(obs()), 32'(exp));
      end

      // Tie with last-served = 1: port 0 first, then port 1.
      fill_port(2'b11);
      expect_grant(1'b0, 6'd0);
      finish_vend(2'b10);
      expect_grant(1'b1, 6'd0);
      finish_vend(2'b00);
      // Serve port 0 alone so the next tie favours port 1.
      fill_port(2'b01);
      expect_grant(1'b0, 6'd0);
      finish_vend(2'b00);
      fill_port(2'b11);
      expect_grant(1'b1, 6'd0);
      finish_vend(2'b01);
      expect_grant(1'b0, 6'd0);
      finish_vend(2'b00);

      // Nickel, then dime with cancel: refund 5, coin rejected.
      cyc(2'b01, 2'b00, 2'b00, 1'b0);
      cyc(2'b01, 2'b01, 2'b01, 1'b0);
      chk("cancel_refund", 32'(refund_view()), 32'({2'b01, 6'd5, 2'b01, 2'b00, 1'b0}));
      cyc(2'b00, 2'b00, 2'b00, 1'b0);
      chk("cancel_quiet", 32'({bus.vend_go, refund_view()}), 32'd0);
      cyc(2'b01, 2'b01, 2'b00, 1'b0);
      chk("credit_cleared", 32'(bus.locked), 32'd0);
      cyc(2'b01, 2'b01, 2'b00, 1'b0);
      chk("relock_20", 32'(bus.locked), 32'd1);

      // Watchdog: no vend_done for 15 WAIT cycles.
      expect_grant(1'b0, 6'd5);
      early_fault = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cyc(2'b00, 2'b00, 2'b00, 1'b0);
         if (bus.fault !== 1'b0) early_fault = 1'b1;
      end
      chk("no_early_fault", 32'(early_fault), 32'd0);
      cyc(2'b00, 2'b00, 2'b00, 1'b0);
      chk("fault_refund", 32'(refund_view()), 32'({2'b01, 6'd20, 2'b00, 2'b01, 1'b1}));
      cyc(2'b00, 2'b00, 2'b00, 1'b0);
      chk("fault_cleanup", 32'(refund_view()), 32'd0);
      cyc(2'b00, 2'b00, 2'b00, 1'b0);
      chk("fault_idle", 32'({bus.vend_go, bus.locked}), 32'd0);

      // Simultaneous cancels: port 0 refunded first, port 1 next; port 1 coin meanwhile rejected.
      cyc(2'b11, 2'b10, 2'b00, 1'b0);
      cyc(2'b00, 2'b00, 2'b11, 1'b0);
      chk("dual_cancel_p0", 32'(refund_view()), 32'({2'b01, 6'd5, 2'b00, 2'b00, 1'b0}));
      cyc(2'b10, 2'b10, 2'b00, 1'b0);
      chk("dual_cancel_p1", 32'(refund_view()), 32'({2'b10, 6'd10, 2'b10, 2'b00, 1'b0}));
      cyc(2'b10, 2'b10, 2'b00, 1'b0);
      chk("p1_after_refund", 32'(refund_view()), 32'd0);
      cyc(2'b00, 2'b00, 2'b10, 1'b0);
      chk("p1_cancel_10", 32'(refund_view()), 32'({2'b10, 6'd10, 2'b00, 2'b00, 1'b0}));

      // Reset in the middle of WAIT, then normal service on port 1.
      fill_port(2'b10);
      expect_grant(1'b1, 6'd0);
      cyc(2'b00, 2'b00, 2'b00, 1'b0);
      #2 rst_ni = 1'b0;
      #1 chk("async_reset_outputs", 32'(obs()), 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      cyc(2'b00, 2'b00, 2'b00, 1'b0);
      chk("after_reset_idle", 32'(obs()), 32'd0);
      fill_port(2'b10);
      expect_grant(1'b1, 6'd0);
      finish_vend(2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
